// File: rtl/bundle_queue.sv
// Multi-lane in-order FIFO carrying flat packed bundles between pipeline stages.
// Accepts up to NI entries and presents up to NO oldest entries per cycle; supports flush and tail kill.
module bundle_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NI    = 2,
    parameter int unsigned NO    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NI+1)-1:0]       in_num,
    input  logic [NI*WIDTH-1:0]           in_data,
    output logic                          in_ready,
    output logic [$clog2(NO+1)-1:0]       out_num,
    output logic [NO*WIDTH-1:0]           out_data,
    input  logic [$clog2(NO+1)-1:0]       out_take,
    input  logic                          flush,
    input  logic                          kill_valid,
    input  logic [$clog2(DEPTH+1)-1:0]    kill_keep
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(NI + 1);
    localparam int unsigned OW = $clog2(NO + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail, head_n, tail_n;
    logic [CW-1:0]    count, count_n, keep_span;
    logic             enq_fire;
    logic [IW-1:0]    enq_num;

    // Status is derived from registered state only, so there is no input-to-output path.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(NI);
    assign out_num  = (count > CW'(NO)) ? OW'(NO) : OW'(count);

    for (genvar j = 0; j < NO; j++) begin : g_out
        assign out_data[j*WIDTH +: WIDTH] = mem[head + PW'(j)];
    end

    assign enq_fire = in_ready && (in_num != '0) && !flush && !kill_valid;
    assign enq_num  = enq_fire ? in_num : '0;

    always_comb begin
        head_n    = head;
        tail_n    = tail;
        count_n   = count;
        keep_span = '0;
        if (flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else if (kill_valid) begin
            // The kept window is measured from the pre-dequeue head.
            keep_span = (kill_keep > CW'(out_take)) ? kill_keep : CW'(out_take);
            head_n    = head + PW'(out_take);
            tail_n    = head + PW'(keep_span);
            count_n   = (kill_keep > CW'(out_take)) ? kill_keep - CW'(out_take) : '0;
        end else begin
            head_n  = head + PW'(out_take);
            tail_n  = tail + PW'(enq_num);
            count_n = count + CW'(enq_num) - CW'(out_take);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (enq_fire && (IW'(i) < in_num)) begin
                mem[tail + PW'(i)] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    a_take_legal: assert property (@(posedge clk) disable iff (rst)
        out_take <= out_num);
    a_keep_legal: assert property (@(posedge clk) disable iff (rst)
        !(kill_valid && !flush) || (kill_keep <= count));
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH));
    a_count_ptr: assert property (@(posedge clk) disable iff (rst)
        PW'(count) == PW'(tail - head));

endmodule
